count_game_ctrl: RTL and testbench
==================================

// Module: count_game_ctrl
// PURPOSE
//  Round sequencer for the counting game. Drives the cst/dzst/num control inputs of the
//  dot-matrix counter and runs a timed round. The player stops the count on a target digit.
//  Each round is judged as hit or miss. The block keeps score over MAX_ROUNDS rounds.
// PARAMETERS
//  TICK_DIV     100  clk cycles per game tick (>=2)
//  ROUND_TICKS  60   ticks in COUNT before the round times out (>=1)
//  SHOW_TICKS   20   ticks the result is held in SHOW (>=1)
//  MAX_ROUNDS   8    rounds per game (1..8)
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  rst        in   1  synchronous reset, active-low
//  start_key  in   1  one-cycle pulse (already debounced); starts or restarts a game
//  stop_key   in   1  one-cycle pulse (already debounced); stops the count
//  target     in   3  target digit, latched on game start and on each ARM entry
//  ct_cst     out  1  counter count-enable
//  ct_dzst    out  1  dot-matrix display enable
//  ct_num     out  3  digit presented to the counter/display
//  round_idx  out  3  current round, 0-based
//  score      out  4  hits this game, saturates at 15
//  win        out  1  result of the last judged round (1 = hit)
//  busy       out  1  high in ARM, COUNT, JUDGE and SHOW
//  game_over  out  1  high in DONE
// BEHAVIOUR
//  - All outputs are registered.
//  - rst=0 sampled at an edge: next cycle state=IDLE and all outputs plus internal counters are 0.
//    This applies from any state, including mid-round.
//  - Tick divider:
//    - div counts 0..TICK_DIV-1. tick=1 in the cycle div==TICK_DIV-1.
//    - div clears on entry to ARM and on entry to SHOW.
//  - States:
//    - IDLE:
//      - all outputs 0.
//      - start_key -> ARM. Latch target; round_idx=0, score=0, win=0.
//    - ARM:
//      - ct_dzst=1, ct_cst=0, ct_num=target.
//      - After one tick -> COUNT; digit=0, tick_cnt=0.
//    - COUNT:
//      - ct_cst=1, ct_dzst=1, ct_num=digit.
//      - On each tick: digit=(digit+1) mod 8 (3-bit wrap), and tick_cnt+1.
//      - stop_key -> JUDGE with stopped=1.
//      - tick_cnt reaching ROUND_TICKS -> JUDGE with stopped=0.
//      - stop_key and timeout in the same cycle: treated as a stop. The digit is the value
//        before that tick's increment.
//    - JUDGE (1 cycle):
//      - ct_cst=0.
//      - win = stopped && (digit==latched target).
//      - If win, score += 1, saturating at 15.
//    - SHOW:
//      - ct_cst=0, ct_dzst=1, ct_num = judged digit.
//      - After SHOW_TICKS ticks: if round_idx==MAX_ROUNDS-1 -> DONE; else round_idx+1 -> ARM.
//    - DONE:
//      - game_over=1, busy=0, ct_dzst=1, ct_num=score[2:0]. score and win are held.
//      - start_key -> ARM with score=0, round_idx=0.
//  - start_key is ignored in ARM, COUNT, JUDGE and SHOW. stop_key is ignored outside COUNT.
//  - Latency: start_key sampled in IDLE at edge N -> busy=1 and ct_dzst=1 after edge N+1.
// TESTING  (TICK_DIV=4, ROUND_TICKS=10, SHOW_TICKS=2, MAX_ROUNDS=2)
//  1. rst=0 for 5 cycles, then rst=1 -> all outputs 0, IDLE; stop_key pulses have no effect.
//  2. target=3, start; stop_key right after the 3rd COUNT tick -> JUDGE digit=3, win=1, score=1.
//  3. No stop_key -> timeout after 10 ticks, win=0, score unchanged, ct_cst drops in JUDGE.
//  4. stop_key after 9 ticks -> digit wraps to 1. With target=1, win=1.
//  5. Play 2 rounds -> DONE, game_over=1, busy=0. start_key -> score=0, round_idx=0, ARM.
//  6. rst=0 mid-COUNT -> next cycle IDLE, ct_cst=0; stop_key on the timeout cycle counts as a stop.

Source files
------------

// File: rtl/count_game_ctrl.sv
// Round sequencer for the counting game: drives the dot-matrix counter,
// times each round, judges hit/miss and keeps score across a game.
module count_game_ctrl #(
    parameter int TICK_DIV    = 100,
    parameter int ROUND_TICKS = 60,
    parameter int SHOW_TICKS  = 20,
    parameter int MAX_ROUNDS  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_key,
    input  logic       stop_key,
    input  logic [2:0] target,
    output logic       ct_cst,
    output logic       ct_dzst,
    output logic [2:0] ct_num,
    output logic [2:0] round_idx,
    output logic [3:0] score,
    output logic       win,
    output logic       busy,
    output logic       game_over
);

    localparam int DW = $clog2(TICK_DIV);
    localparam int CMAX = (ROUND_TICKS > SHOW_TICKS) ? ROUND_TICKS : SHOW_TICKS;
    localparam int CW = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_COUNT, S_JUDGE, S_SHOW, S_DONE
    } state_t;

    state_t state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] digit_q, digit_d;
    logic [2:0] tgt_q, tgt_d;
    logic [2:0] round_q, round_d;
    logic [3:0] score_q, score_d;
    logic stopped_q, stopped_d;
    logic win_q, win_d;
    logic cst_q, cst_d;
    logic dzst_q, dzst_d;
    logic [2:0] num_q, num_d;
    logic busy_q, busy_d;
    logic over_q, over_d;
    logic tick;

    assign tick = (div_q == DW'(TICK_DIV - 1));

    always_comb begin
        state_d   = state_q;
        div_d     = tick ? '0 : div_q + DW'(1);
        cnt_d     = cnt_q;
        digit_d   = digit_q;
        tgt_d     = tgt_q;
        round_d   = round_q;
        score_d   = score_q;
        stopped_d = stopped_q;
        win_d     = win_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_key) begin
                    state_d = S_ARM;
                    tgt_d   = target;
                    round_d = '0;
                    score_d = '0;
                    win_d   = 1'b0;
                    div_d   = '0;
                end
            end
            S_ARM: begin
                if (tick) begin
                    state_d = S_COUNT;
                    digit_d = '0;
                    cnt_d   = '0;
                end
            end
            S_COUNT: begin
                // A stop wins over a coinciding tick, so the digit is not advanced.
                if (stop_key) begin
                    state_d   = S_JUDGE;
                    stopped_d = 1'b1;
                end else if (tick) begin
                    digit_d = digit_q + 3'd1;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(ROUND_TICKS - 1)) begin
                        state_d   = S_JUDGE;
                        stopped_d = 1'b0;
                    end
                end
            end
            S_JUDGE: begin
                win_d = stopped_q && (digit_q == tgt_q);
                if (win_d && (score_q != 4'hf)) begin
                    score_d = score_q + 4'd1;
                end
                state_d = S_SHOW;
                div_d   = '0;
                cnt_d   = '0;
            end
            S_SHOW: begin
                if (tick) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(SHOW_TICKS - 1)) begin
                        if (round_q == 3'(MAX_ROUNDS - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_ARM;
                            round_d = round_q + 3'd1;
                            tgt_d   = target;
                            div_d   = '0;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cst_d  = (state_q == S_COUNT);
        dzst_d = (state_q != S_IDLE);
        busy_d = (state_q != S_IDLE) && (state_q != S_DONE);
        over_d = (state_q == S_DONE);
        num_d  = '0;
        case (state_q)
            S_ARM:                    num_d = tgt_q;
            S_COUNT, S_JUDGE, S_SHOW: num_d = digit_q;
            S_DONE:                   num_d = score_q[2:0];
            default:                  num_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            cnt_q     <= '0;
            digit_q   <= '0;
            tgt_q     <= '0;
            round_q   <= '0;
            score_q   <= '0;
            stopped_q <= 1'b0;
            win_q     <= 1'b0;
            cst_q     <= 1'b0;
            dzst_q    <= 1'b0;
            num_q     <= '0;
            busy_q    <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            digit_q   <= digit_d;
            tgt_q     <= tgt_d;
            round_q   <= round_d;
            score_q   <= score_d;
            stopped_q <= stopped_d;
            win_q     <= win_d;
            cst_q     <= cst_d;
            dzst_q    <= dzst_d;
            num_q     <= num_d;
            busy_q    <= busy_d;
            over_q    <= over_d;
        end
    end

    assign ct_cst    = cst_q;
    assign ct_dzst   = dzst_q;
    assign ct_num    = num_q;
    assign round_idx = round_q;
    assign score     = score_q;
    assign win       = win_q;
    assign busy      = busy_q;
    assign game_over = over_q;

endmodule

// File: tb/tb_count_game_ctrl.sv
// Directed bench for count_game_ctrl: table of rounds plus reset sequences.
module tb_count_game_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_key = 1'b0;
    logic stop_key = 1'b0;
    logic [2:0] target = '0;
    logic ct_cst, ct_dzst, win, busy, game_over;
    logic [2:0] ct_num, round_idx;
    logic [3:0] score;

    int nvec = 0;
    int nmis = 0;

    count_game_ctrl #(
        .TICK_DIV(4), .ROUND_TICKS(10), .SHOW_TICKS(2), .MAX_ROUNDS(2)
    ) dut (
        .clk(clk), .rst(rst), .start_key(start_key), .stop_key(stop_key),
        .target(target), .ct_cst(ct_cst), .ct_dzst(ct_dzst), .ct_num(ct_num),
        .round_idx(round_idx), .score(score), .win(win), .busy(busy),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    // k: edge (relative to ARM entry) at which stop_key is sampled; 0 = none
    typedef struct {
        logic [2:0] tgt;
        int         k;
        logic [2:0] dig;
        logic       w;
        logic [3:0] sc;
    } vec_t;

    vec_t tbl[6];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int all_o();
        return int'({ct_cst, ct_dzst, ct_num, round_idx, score, win, busy,
                     game_over});
    endfunction

    task automatic run_vec(input int i);
        int r;
        int kk;
        vec_t v;
        r = i % 2;
        v = tbl[i];
        if (r == 0) begin
            target = v.tgt;
            start_key = 1'b1;
            step(1);
            start_key = 1'b0;
        end
        step(1);
        chk($sformatf("v%0d busy", i), busy, 1);
        chk($sformatf("v%0d dzst", i), ct_dzst, 1);
        chk($sformatf("v%0d arm_cst", i), ct_cst, 0);
        chk($sformatf("v%0d arm_num", i), ct_num, v.tgt);
        chk($sformatf("v%0d round", i), round_idx, r);
        if (r == 0) begin
            chk($sformatf("v%0d score0", i), score, 0);
            chk($sformatf("v%0d win0", i), win, 0);
        end
        kk = (v.k == 0) ? 44 : v.k;
        step(kk - 2);
        if (v.k != 0) stop_key = 1'b1;
        step(1);
        stop_key = 1'b0;
        chk($sformatf("v%0d count_cst", i), ct_cst, 1);
        step(1);
        chk($sformatf("v%0d win", i), win, v.w);
        chk($sformatf("v%0d score", i), score, v.sc);
        chk($sformatf("v%0d judge_cst", i), ct_cst, 0);
        chk($sformatf("v%0d digit", i), ct_num, v.dig);
        if (r == 0) begin
            target = tbl[i + 1].tgt;
            start_key = 1'b1;
            step(1);
            start_key = 1'b0;
            step(7);
        end else begin
            step(8);
            step(1);
            chk($sformatf("v%0d over", i), game_over, 1);
            chk($sformatf("v%0d done_busy", i), busy, 0);
            chk($sformatf("v%0d done_dzst", i), ct_dzst, 1);
            chk($sformatf("v%0d done_num", i), ct_num, int'(v.sc[2:0]));
        end
    endtask

    initial begin
        tbl[0] = '{tgt: 3'd3, k: 17, dig: 3'd3, w: 1'b1, sc: 4'd1};
        tbl[1] = '{tgt: 3'd5, k: 0,  dig: 3'd2, w: 1'b0, sc: 4'd1};
        tbl[2] = '{tgt: 3'd1, k: 41, dig: 3'd1, w: 1'b1, sc: 4'd1};
        tbl[3] = '{tgt: 3'd1, k: 44, dig: 3'd1, w: 1'b1, sc: 4'd2};
        tbl[4] = '{tgt: 3'd2, k: 5,  dig: 3'd0, w: 1'b0, sc: 4'd0};
        tbl[5] = '{tgt: 3'd1, k: 9,  dig: 3'd1, w: 1'b1, sc: 4'd1};

        step(2);
        stop_key = 1'b1;
        step(1);
        stop_key = 1'b0;
        step(2);
        chk("reset_outs", all_o(), 0);
        rst = 1'b1;
        stop_key = 1'b1;
        step(1);
        stop_key = 1'b0;
        step(2);
        chk("idle_outs", all_o(), 0);

        for (int i = 0; i < 6; i++) run_vec(i);

        target = 3'd4;
        start_key = 1'b1;
        step(1);
        start_key = 1'b0;
        step(10);
        chk("mid_cst", ct_cst, 1);
        rst = 1'b0;
        step(1);
        chk("midrst_outs", all_o(), 0);
        chk("midrst_cst", ct_cst, 0);
        rst = 1'b1;
        stop_key = 1'b1;
        step(1);
        stop_key = 1'b0;
        step(2);
        chk("post_midrst", all_o(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
